// File: rtl/frmsync_ctl.sv
// Frame-alignment controller: hunts for the 8 kHz frame pulse, locks onto it and
// flywheels through missing or corrupted pulses.
module frmsync_ctl #(
  parameter int unsigned FRMLEN = 2430,
  parameter int unsigned CNTW   = 12,
  parameter int unsigned NLOCK  = 3,
  parameter int unsigned NLOSS  = 4
) (
  input  logic            iclk19,
  input  logic            rst,
  input  logic            ien,
  input  logic            iframe,
  output logic            ofrmsync,
  output logic [CNTW-1:0] ofrmcnt,
  output logic            olock,
  output logic            oerr,
  output logic [1:0]      ostate
);

  localparam int unsigned MW = (NLOCK > 1) ? $clog2(NLOCK + 1) : 1;
  localparam int unsigned LW = (NLOSS > 1) ? $clog2(NLOSS + 1) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(FRMLEN - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [MW-1:0]   match_q, match_d;
  logic [LW-1:0]   miss_q, miss_d;
  logic            bad_q, bad_d;
  logic            err_q, err_d;
  logic            sync_q, lock_q, iframe_q;
  logic            rise_c, wrap_c, realign_c;

  assign rise_c = iframe & ~iframe_q;
  assign wrap_c = (cnt_q == LAST);

  // Next-state, alignment and error evaluation
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    miss_d    = miss_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    realign_c = 1'b0;

    if (!ien) begin
      state_d = HUNT;
      match_d = '0;
      miss_d  = '0;
      bad_d   = 1'b0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (rise_c) begin
            realign_c = 1'b1;
            match_d   = MW'(1);
            miss_d    = '0;
            state_d   = (NLOCK == 1) ? SYNC : PRESYNC;
          end
        end
        PRESYNC: begin
          if (rise_c && wrap_c) begin
            if (match_q == MW'(NLOCK - 1)) begin
              state_d = SYNC;
              match_d = MW'(NLOCK);
              miss_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (rise_c) begin
            realign_c = 1'b1;
            match_d   = MW'(1);
          end else if (wrap_c) begin
            state_d = HUNT;
            match_d = '0;
          end
        end
        SYNC: begin
          // Flywheel: judge each frame at its wrap, never realign
          if (rise_c && !wrap_c) bad_d = 1'b1;
          if (wrap_c) begin
            bad_d = 1'b0;
            if (rise_c && !bad_q) begin
              miss_d = '0;
            end else begin
              err_d = 1'b1;
              if (miss_q == LW'(NLOSS - 1)) begin
                state_d = HUNT;
                miss_d  = '0;
                match_d = '0;
              end else begin
                miss_d = miss_q + LW'(1);
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          match_d = '0;
          miss_d  = '0;
          bad_d   = 1'b0;
        end
      endcase
    end

    cnt_d = (wrap_c || realign_c) ? '0 : cnt_q + CNTW'(1);
  end

  always_ff @(posedge iclk19 or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
      sync_q   <= 1'b0;
      lock_q   <= 1'b0;
      iframe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      sync_q   <= wrap_c | realign_c;
      lock_q   <= (state_d == SYNC);
      iframe_q <= iframe;
    end
  end

  assign ofrmsync = sync_q;
  assign ofrmcnt  = cnt_q;
  assign olock    = lock_q;
  assign oerr     = err_q;
  assign ostate   = state_q;

endmodule
